mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports clk, rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous reset, active-high (`RstEnable`).
REQ-004 rdy  in  1  low: hold all state and registered outputs.
REQ-005 if_req  in  1  instruction fetch request; if_addr  in  32  fetch byte address.
REQ-006 if_done  out  1  one-cycle pulse, if_inst valid; if_inst  out  32  fetched word.
REQ-007 mem_req  in  1  load/store request; mem_we  in  1  1=store; mem_addr  in  32; mem_wdata  in  32.
REQ-008 mem_len  in  2  0=byte, 1=half, 2 or 3=word.
REQ-009 mem_done  out  1  one-cycle pulse; mem_rdata  out  32  load data, zero-extended.
REQ-010 ram_din  in  8; ram_dout  out  8; ram_addr  out  32; ram_wr  out  1 (1=write).
REQ-011 stall_if  out  1 and stall_mem  out  1  stall requests to stall controller.

Function
REQ-012 SHALL use states IDLE, BUSY, DONE; one transaction at a time, N = 1/2/4 bytes (fetch always 4).
REQ-013 IDLE, edge E0: mem_req=1 accepted first; else if_req=1; latch addr/len/we/wdata/owner; ram_addr=addr; ram_wr=we; ram_dout=wdata[7:0]; go BUSY.
REQ-014 Byte i (0..N-1) SHALL be presented on ram_addr after edge Ei, ram_addr = base+i, 32-bit wrap.
REQ-015 RAM read latency is 2 edges: byte presented after Ei is on ram_din after E(i+1) and captured at E(i+2), little-endian into bits [8i+7:8i].
REQ-016 Read: capture last byte at E(N+1); same edge set owner done=1 and enter DONE (word: E5, byte: E2).
REQ-017 Write: ram_dout = wdata[8i+7:8i] with ram_wr=1 after E0..E(N-1); at EN ram_wr=0, done=1, enter DONE.
REQ-018 ram_wr SHALL be 0 at all times except during store byte cycles.
REQ-019 DONE lasts exactly one cycle, accepts no request, returns IDLE; done pulse clears at that edge.
REQ-020 Earliest next acceptance is the edge ending the IDLE cycle after DONE.
REQ-021 In-progress transaction SHALL NOT be preempted; deasserting req mid-transaction does not abort; done still pulses.
REQ-022 mem_rdata upper bytes beyond N SHALL be 0; if_inst/mem_rdata hold value until next capture of same owner.
REQ-023 stall_if = if_req & ~if_done; stall_mem = mem_req & ~mem_done (combinational); both 0 while rst=1.
REQ-024 rdy=0 at an edge: no state, counter, output or capture change; RAM byte pending on ram_din re-captured correctly by holding ram_addr.

Reset
REQ-025 At rst edge: state=IDLE, counters=0, ram_wr=0, ram_addr=0, ram_dout=0, if_done=0, mem_done=0, if_inst=0, mem_rdata=0.
REQ-026 Reset mid-transaction SHALL abort it with no done pulse; ram_wr=0 from that edge.
REQ-027 rst has priority over rdy.

Verification
REQ-028 RAM[0x1000..3]=13,05,10,00; if_req at 0x1000 -> if_done high after E5 only, if_inst=0x00100513, stall_if high until then.
REQ-029 if_req and mem_req (load word 0x2000) same cycle -> mem served first, mem_done after E5; fetch accepted after DONE+IDLE.
REQ-030 Store byte 0xAB at 0x2003 -> ram_wr=1 one cycle, ram_addr=0x2003, ram_dout=0xAB; mem_done after E1.
REQ-031 Store word 0x11223344 at 0xFFFFFFFE -> addresses FFFFFFFE,FFFFFFFF,0,1 with data 44,33,22,11.
REQ-032 rst at E2 of word store -> ram_wr=0 after E2, no mem_done, IDLE; rdy=0 for 3 cycles mid-load -> same data, done delayed 3 cycles.

Source files
------------

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Byte-serial memory controller that arbitrates instruction
//                fetch and load/store requests onto an 8-bit synchronous RAM
//                port. One transaction at a time: 1, 2 or 4 bytes,
//                little-endian. The RAM read latency is two edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_len,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic        stall_if,
    output logic        stall_mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [2:0]  r_cnt;        // BUSY edges elapsed since acceptance
    logic [2:0]  r_len;        // transaction length in bytes (1, 2 or 4)
    logic        r_we;
    logic        r_own_mem;    // 1 = load/store port owns the transaction
    logic [31:0] r_wdata;
    logic [31:0] r_buf;        // read bytes assembled so far
    logic [31:0] r_ram_addr;
    logic [7:0]  r_ram_dout;
    logic        r_ram_wr;
    logic        r_if_done;
    logic        r_mem_done;
    logic [31:0] r_if_inst;
    logic [31:0] r_mem_rdata;

    logic        w_accept;
    logic        w_take_mem;
    logic [2:0]  w_req_len;
    logic [2:0]  w_k;          // index of the edge being processed (E1, E2, ...)
    logic [1:0]  w_cap_idx;
    logic        w_capture;
    logic        w_finish;
    logic [31:0] w_buf_next;
    logic [7:0]  w_wbyte;

    // The load/store port wins when both ports request in the same cycle.
    assign w_take_mem = mem_req;
    assign w_accept   = (r_state == S_IDLE) && (mem_req || if_req);
    assign w_req_len  = !w_take_mem        ? 3'd4 :
                        (mem_len == 2'd0)  ? 3'd1 :
                        (mem_len == 2'd1)  ? 3'd2 : 3'd4;

    assign w_k        = r_cnt + 3'd1;
    // Byte presented after edge Ei is captured at edge E(i+2).
    assign w_cap_idx  = w_k[1:0] - 2'd2;
    assign w_capture  = (r_state == S_BUSY) && !r_we && (w_k >= 3'd2);
    assign w_finish   = (r_state == S_BUSY) &&
                        (r_we ? (w_k == r_len) : (w_k == r_len + 3'd1));
    assign w_buf_next = r_buf | ({24'd0, ram_din} << {w_cap_idx, 3'b000});
    assign w_wbyte    = r_wdata[{w_k[1:0], 3'b000} +: 8];

    assign if_done    = r_if_done;
    assign if_inst    = r_if_inst;
    assign mem_done   = r_mem_done;
    assign mem_rdata  = r_mem_rdata;
    assign ram_dout   = r_ram_dout;
    assign ram_addr   = r_ram_addr;
    assign ram_wr     = r_ram_wr;
    assign stall_if   = !rst && if_req  && !r_if_done;
    assign stall_mem  = !rst && mem_req && !r_mem_done;

    // State register; rst overrides rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; nothing advances while rdy is low.
    always_comb begin
        w_next_state = r_state;
        if (rdy) begin
            case (r_state)
                S_IDLE:  if (w_accept) w_next_state = S_BUSY;
                S_BUSY:  if (w_finish) w_next_state = S_DONE;
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Datapath: latch request, walk RAM addresses, capture bytes, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 3'd0;
            r_len       <= 3'd0;
            r_we        <= 1'b0;
            r_own_mem   <= 1'b0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_ram_addr  <= 32'd0;
            r_ram_dout  <= 8'd0;
            r_ram_wr    <= 1'b0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_inst   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= 3'd0;
                        r_buf      <= 32'd0;
                        r_len      <= w_req_len;
                        r_own_mem  <= w_take_mem;
                        r_we       <= w_take_mem && mem_we;
                        r_wdata    <= w_take_mem ? mem_wdata : 32'd0;
                        r_ram_addr <= w_take_mem ? mem_addr : if_addr;
                        r_ram_wr   <= w_take_mem && mem_we;
                        r_ram_dout <= w_take_mem ? mem_wdata[7:0] : 8'd0;
                    end
                end
                S_BUSY: begin
                    r_cnt <= w_k;
                    if (w_k < r_len) begin
                        r_ram_addr <= r_ram_addr + 32'd1;
                        r_ram_dout <= w_wbyte;
                    end
                    if (w_capture) begin
                        r_buf <= w_buf_next;
                    end
                    if (w_finish) begin
                        r_ram_wr <= 1'b0;
                        if (r_own_mem) begin
                            r_mem_done <= 1'b1;
                            if (!r_we) r_mem_rdata <= w_buf_next;
                        end else begin
                            r_if_done <= 1'b1;
                            r_if_inst <= w_buf_next;
                        end
                    end
                end
                S_DONE: begin
                    r_if_done  <= 1'b0;
                    r_mem_done <= 1'b0;
                end
                default: begin
                    r_ram_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Self-checking bench for mem_ctrl: directed vector table,
//                randomized transactions against a byte-array reference
//                model, and hand sequences for arbitration, reset and rdy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_len;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic        stall_if;
    logic        stall_mem;

    mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_inst   (if_inst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_len   (mem_len),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    // RAM environment (64 KiB window, address aliased on low 16 bits) and
    // the reference model's own view of memory.
    logic [7:0]  ram_mem   [0:65535];
    logic [7:0]  model_mem [0:65535];
    logic [31:0] log_addr[$];
    logic [7:0]  log_data[$];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_if_inst;
    logic [31:0] exp_mem_rdata;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          st_after;
        int          st_cyc;
        int          lat;
        logic [31:0] data;
    } vec_t;

    vec_t vt[11];

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC3;
    endfunction

    function automatic int nbytes(input bit is_mem, input logic [1:0] len);
        if (!is_mem)         return 4;
        if (len == 2'd0)     return 1;
        if (len == 2'd1)     return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
        logic [31:0] d;
        logic [31:0] a;
        d = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + i;
            d[8*i +: 8] = model_mem[a[15:0]];
        end
        return d;
    endfunction

    // Synchronous RAM: two-edge read latency as seen by the controller;
    // frozen together with the controller while rdy is low.
    always @(posedge clk) begin
        if (rdy) begin
            ram_din <= ram_mem[ram_addr[15:0]];
            if (ram_wr) begin
                ram_mem[ram_addr[15:0]] <= ram_dout;
                log_addr.push_back(ram_addr);
                log_data.push_back(ram_dout);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_txn(input bit is_mem, input bit we, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int st_after, input int st_cyc,
                           input int exp_lat, input logic [31:0] exp_data);
        int          k;
        int          done_k;
        int          stall_left;
        int          n;
        bit          stall_ok;
        logic [31:0] a;
        n = nbytes(is_mem, len);
        @(negedge clk);
        log_addr.delete();
        log_data.delete();
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        @(posedge clk); #1;
        k = 0; done_k = -1; stall_left = 0; stall_ok = 1'b1;
        if (st_cyc > 0 && st_after == 0) begin rdy = 1'b0; stall_left = st_cyc; end
        while (done_k < 0 && k < 40) begin
            if ((is_mem ? stall_mem : stall_if) !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            k++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) rdy = 1'b1;
            end else if (st_cyc > 0 && k == st_after) begin
                rdy = 1'b0; stall_left = st_cyc;
            end
            if ((is_mem ? mem_done : if_done) === 1'b1) done_k = k;
        end
        rdy = 1'b1;
        chk("done_latency", done_k, exp_lat);
        chk("stall_before_done", {31'd0, stall_ok}, 32'd1);
        chk("stall_at_done", {31'd0, is_mem ? stall_mem : stall_if}, 32'd0);
        chk("other_done", {31'd0, is_mem ? if_done : mem_done}, 32'd0);
        if (!we) begin
            if (is_mem) exp_mem_rdata = exp_data;
            else        exp_if_inst   = exp_data;
        end
        chk("if_inst", if_inst, exp_if_inst);
        chk("mem_rdata", mem_rdata, exp_mem_rdata);
        chk("wr_count", log_addr.size(), we ? n : 0);
        if (we) begin
            for (int i = 0; i < n && i < log_addr.size(); i++) begin
                a = addr + i;
                chk("wr_addr", log_addr[i], a);
                chk("wr_data", {24'd0, log_data[i]}, {24'd0, wdata[8*i +: 8]});
                model_mem[a[15:0]] = wdata[8*i +: 8];
            end
        end
        @(posedge clk); #1;
        chk("done_clear", {31'd0, is_mem ? mem_done : if_done}, 32'd0);
        chk("wr_idle", {31'd0, ram_wr}, 32'd0);
        mem_req = 1'b0;
        if_req  = 1'b0;
    endtask

    initial begin
        int          k;
        int          mem_k;
        int          if_k;
        int          n;
        int          base;
        int          sa;
        int          sc;
        bit          is_mem;
        bit          we;
        bit          bad;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] got_m;
        logic [31:0] got_i;
        logic [31:0] exp_m;

        for (int i = 0; i < 65536; i++) begin
            ram_mem[i]   <= init_byte(i[15:0]);
            model_mem[i]  = init_byte(i[15:0]);
        end
        ram_mem[16'h1000] <= 8'h13; ram_mem[16'h1001] <= 8'h05;
        ram_mem[16'h1002] <= 8'h10; ram_mem[16'h1003] <= 8'h00;
        model_mem[16'h1000] = 8'h13; model_mem[16'h1001] = 8'h05;
        model_mem[16'h1002] = 8'h10; model_mem[16'h1003] = 8'h00;

        vt[0]  = '{1'b0, 1'b0, 2'd0, 32'h0000_1000, 32'h0,         0, 0, 5, 32'h0010_0513};
        vt[1]  = '{1'b1, 1'b1, 2'd0, 32'h0000_2003, 32'hFFFF_FFAB, 0, 0, 1, 32'h0};
        vt[2]  = '{1'b1, 1'b0, 2'd0, 32'h0000_2003, 32'h0,         0, 0, 2, 32'h0000_00AB};
        vt[3]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'h1122_3344, 0, 0, 4, 32'h0};
        vt[4]  = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0,         0, 0, 5, 32'h1122_3344};
        vt[5]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0000, 32'h0,         0, 0, 3, 32'h0000_1122};
        vt[6]  = '{1'b1, 1'b1, 2'd1, 32'h0000_3000, 32'h1234_BEEF, 0, 0, 2, 32'h0};
        vt[7]  = '{1'b0, 1'b0, 2'd0, 32'h0000_3000, 32'h0,         0, 0, 5, 32'hF0F1_BEEF};
        vt[8]  = '{1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0,         2, 3, 8, 32'h0010_0513};
        vt[9]  = '{1'b1, 1'b1, 2'd3, 32'h0000_5000, 32'hCAFE_F00D, 1, 2, 6, 32'h0};
        vt[10] = '{1'b1, 1'b0, 2'd2, 32'h0000_5000, 32'h0,         0, 1, 6, 32'hCAFE_F00D};

        // Reset: stall outputs gated while rst is high even with requests up.
        rst = 1'b1; rdy = 1'b1; if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
        if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_len = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall_if", {31'd0, stall_if}, 32'd0);
        chk("rst_stall_mem", {31'd0, stall_mem}, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        chk("rst_done", {30'd0, if_done, mem_done}, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        if_req = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_if_inst = 32'd0; exp_mem_rdata = 32'd0;

        // Directed vector table.
        for (int v = 0; v < 11; v++) begin
            run_txn(vt[v].is_mem, vt[v].we, vt[v].len, vt[v].addr, vt[v].wdata,
                    vt[v].st_after, vt[v].st_cyc, vt[v].lat, vt[v].data);
        end

        // Simultaneous fetch and load: load first, fetch after DONE + IDLE.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd2; mem_addr = 32'h0000_2000;
        if_req = 1'b1; if_addr = 32'h0000_1000;
        exp_m = model_read(32'h0000_2000, 4);
        @(posedge clk); #1;
        k = 0; mem_k = -1; if_k = -1; got_m = 32'd0; got_i = 32'd0;
        while ((mem_k < 0 || if_k < 0) && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (mem_done === 1'b1 && mem_k < 0) begin mem_k = k; got_m = mem_rdata; end
            if (if_done === 1'b1 && if_k < 0) begin if_k = k; got_i = if_inst; end
            if (mem_k >= 0 && mem_done !== 1'b1) mem_req = 1'b0;
        end
        if_req = 1'b0;
        chk("arb_mem_latency", mem_k, 5);
        chk("arb_if_latency", if_k, 12);
        chk("arb_mem_data", got_m, exp_m);
        chk("arb_if_data", got_i, 32'h0010_0513);
        exp_mem_rdata = exp_m; exp_if_inst = 32'h0010_0513;
        @(posedge clk); #1;

        // Randomized transactions against the reference model.
        for (int t = 0; t < 24; t++) begin
            is_mem = ($urandom_range(0, 3) != 0);
            we     = is_mem && ($urandom_range(0, 1) == 1);
            len    = 2'($urandom_range(0, 3));
            addr   = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFFC + $urandom_range(0, 3))
                                                 : (32'h0000_8000 + $urandom_range(0, 63));
            wdata  = $urandom;
            n      = nbytes(is_mem, len);
            base   = we ? n : n + 1;
            sa = 0; sc = 0;
            if ($urandom_range(0, 3) == 0) begin
                sa = $urandom_range(0, base - 1);
                sc = $urandom_range(1, 3);
            end
            run_txn(is_mem, we, len, addr, wdata, sa, sc, base + sc,
                    we ? 32'd0 : model_read(addr, n));
        end

        // Reset in the middle of a word store (with rdy low: rst wins).
        @(negedge clk);
        log_addr.delete(); log_data.delete();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2;
        mem_addr = 32'h0000_4000; mem_wdata = 32'h5566_7788;
        @(posedge clk); #1;
        mem_req = 1'b0;
        @(posedge clk); #1;
        chk("abort_wr_before", {31'd0, ram_wr}, 32'd1);
        chk("abort_addr_before", ram_addr, 32'h0000_4001);
        rst = 1'b1; rdy = 1'b0; mem_req = 1'b1; if_req = 1'b1;
        @(posedge clk); #1;
        chk("abort_wr", {31'd0, ram_wr}, 32'd0);
        chk("abort_ram_addr", ram_addr, 32'd0);
        chk("abort_done", {30'd0, if_done, mem_done}, 32'd0);
        chk("abort_stall", {30'd0, stall_if, stall_mem}, 32'd0);
        chk("abort_if_inst", if_inst, 32'd0);
        chk("abort_mem_rdata", mem_rdata, 32'd0);
        mem_req = 1'b0; if_req = 1'b0; rdy = 1'b1; rst = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (mem_done !== 1'b0 || ram_wr !== 1'b0) bad = 1'b1;
        end
        chk("abort_quiet", {31'd0, bad}, 32'd0);
        exp_if_inst = 32'd0; exp_mem_rdata = 32'd0;

        // Controller returns to service after the aborted store.
        run_txn(1'b1, 1'b0, 2'd1, 32'h0000_1002, 32'd0, 0, 0, 3, 32'h0000_0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
